mod_lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that accumulates weighted synaptic events into a membrane potential, applies a periodic leak, and emits a spike on threshold crossing. It sits directly upstream of the spike-holding D latch. `spikeOut` drives the latch `dataIn`, and `crit` drives the latch enable. The latch therefore captures a high level on fire and a low level when the refractory period ends, so downstream leg logic sees a clean spike level.

---
 rtl/mod_lif_neuron.sv | 189 ++++++++++++++++++
 tb/tb_mod_lif_neuron.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_lif_neuron.sv
// ---------------------------------------------------------------------------
// mod_lif_neuron
//
// Leaky integrate-and-fire neuron. Weighted synaptic events are accumulated
// into an unsigned, saturating membrane potential. A leak of
// potential >> LEAK_SHIFT is removed once every LEAK_PERIOD cycles. When the
// potential reaches THRESHOLD the neuron fires: one FIRE cycle followed by
// REFRACTORY cycles of REFRACT, then back to INTEGRATE.
//
// spikeOut/crit are shaped for a downstream D latch (spikeOut -> dataIn,
// crit -> enable). crit pulses high in FIRE with spikeOut=1 so the latch
// captures a 1. It pulses high again in the last REFRACT cycle with
// spikeOut=0 so the latch captures a 0.
//
// Event handshake: synValid/synWeight form a valid-only stream with no
// back-pressure. An event is consumed at a rising edge when synValid=1 and
// the neuron is in INTEGRATE. Events presented in FIRE or REFRACT are
// dropped.
//
// Ports
//   clk         in   single clock, rising edge
//   rstN        in   synchronous active-low reset
//   synValid    in   synaptic event present this cycle
//   synWeight   in   signed event weight (WEIGHT_W bits)
//   spikeOut    out  spike level for the latch data input
//   crit        out  one-cycle latch-enable strobe
//   potential   out  registered membrane potential (WIDTH bits)
//   refractory  out  high in FIRE and REFRACT
//   o_dbg_state out  current FSM state (0 INTEGRATE, 1 FIRE, 2 REFRACT)
// ---------------------------------------------------------------------------
module mod_lif_neuron #(
    parameter int WIDTH       = 8,
    parameter int WEIGHT_W    = 8,
    parameter int THRESHOLD   = 100,
    parameter int LEAK_SHIFT  = 3,
    parameter int LEAK_PERIOD = 16,
    parameter int REFRACTORY  = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       synValid,
    input  logic signed [WEIGHT_W-1:0] synWeight,
    output logic                       spikeOut,
    output logic                       crit,
    output logic        [WIDTH-1:0]    potential,
    output logic                       refractory,
    output logic        [1:0]          o_dbg_state
);

    localparam int SUM_W  = WIDTH + WEIGHT_W + 1;
    localparam int LCNT_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RCNT_W = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;

    localparam logic [LCNT_W-1:0] LEAK_LAST = LCNT_W'(LEAK_PERIOD - 1);
    localparam logic [RCNT_W-1:0] REF_LAST  = RCNT_W'(REFRACTORY - 1);
    // Index of the REFRACT cycle just before the final one; only used when
    // REFRACTORY >= 2.
    localparam logic [RCNT_W-1:0] REF_PENULT =
        RCNT_W'((REFRACTORY >= 2) ? (REFRACTORY - 2) : 0);
    // With a single REFRACT cycle, that cycle is already the exit strobe.
    localparam bit REF_SINGLE = (REFRACTORY == 1);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    state_t                r_state;
    logic [LCNT_W-1:0]     r_leak_cnt;
    logic [RCNT_W-1:0]     r_ref_cnt;
    logic [WIDTH-1:0]      r_potential;
    logic                  r_spike;
    logic                  r_crit;
    logic                  r_refr;

    logic                  w_tick;
    logic [WIDTH-1:0]      w_leak_amt;
    logic [WIDTH-1:0]      w_p1;
    logic signed [SUM_W-1:0] w_p1_ext;
    logic signed [SUM_W-1:0] w_weight_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic [WIDTH-1:0]      w_clamped;
    logic                  w_fire;

    // Leak is applied first; p - (p >> k) can never underflow.
    assign w_tick     = (r_leak_cnt == LEAK_LAST);
    assign w_leak_amt = r_potential >> LEAK_SHIFT;
    assign w_p1       = w_tick ? (r_potential - w_leak_amt) : r_potential;

    // Wide signed sum: zero-extended potential plus sign-extended weight.
    assign w_p1_ext     = {{(SUM_W - WIDTH){1'b0}}, w_p1};
    assign w_weight_ext = synValid
                        ? {{(SUM_W - WEIGHT_W){synWeight[WEIGHT_W-1]}}, synWeight}
                        : '0;
    assign w_sum        = w_p1_ext + w_weight_ext;

    // Saturate: negative -> 0, any bit above WIDTH set -> all ones.
    always_comb begin
        w_clamped = w_sum[WIDTH-1:0];
        if (w_sum[SUM_W-1]) begin
            w_clamped = '0;
        end else if (|w_sum[SUM_W-2:WIDTH]) begin
            w_clamped = '1;
        end
    end

    assign w_fire = (w_clamped >= WIDTH'(THRESHOLD));

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state     <= ST_INTEGRATE;
            r_leak_cnt  <= '0;
            r_ref_cnt   <= '0;
            r_potential <= '0;
            r_spike     <= 1'b0;
            r_crit      <= 1'b0;
            r_refr      <= 1'b0;
        end else begin
            // Leak counter runs in every state.
            r_leak_cnt <= w_tick ? '0 : (r_leak_cnt + 1'b1);

            case (r_state)
                ST_INTEGRATE: begin
                    if (w_fire) begin
                        r_state     <= ST_FIRE;
                        r_potential <= '0;
                        r_spike     <= 1'b1;
                        r_crit      <= 1'b1;
                        r_refr      <= 1'b1;
                    end else begin
                        r_potential <= w_clamped;
                        r_spike     <= 1'b0;
                        r_crit      <= 1'b0;
                        r_refr      <= 1'b0;
                    end
                end

                ST_FIRE: begin
                    r_state     <= ST_REFRACT;
                    r_ref_cnt   <= '0;
                    r_potential <= '0;
                    r_refr      <= 1'b1;
                    r_spike     <= !REF_SINGLE;
                    r_crit      <= REF_SINGLE;
                end

                ST_REFRACT: begin
                    r_potential <= '0;
                    if (r_ref_cnt == REF_LAST) begin
                        r_state   <= ST_INTEGRATE;
                        r_ref_cnt <= '0;
                        r_spike   <= 1'b0;
                        r_crit    <= 1'b0;
                        r_refr    <= 1'b0;
                    end else begin
                        r_ref_cnt <= r_ref_cnt + 1'b1;
                        r_refr    <= 1'b1;
                        // Entering the final REFRACT cycle: exit strobe with
                        // spikeOut low so the latch captures 0.
                        if (r_ref_cnt == REF_PENULT) begin
                            r_spike <= 1'b0;
                            r_crit  <= 1'b1;
                        end else begin
                            r_spike <= 1'b1;
                            r_crit  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_INTEGRATE;
                    r_ref_cnt   <= '0;
                    r_potential <= '0;
                    r_spike     <= 1'b0;
                    r_crit      <= 1'b0;
                    r_refr      <= 1'b0;
                end
            endcase
        end
    end

    assign spikeOut    = r_spike;
    assign crit        = r_crit;
    assign potential   = r_potential;
    assign refractory  = r_refr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mod_lif_neuron.sv
// ---------------------------------------------------------------------------
// tb_mod_lif_neuron
//
// Bench for mod_lif_neuron. The main instance uses default parameters and is
// tracked by a cycle-level behavioural model (refractory modelled as a
// countdown of remaining non-integrating cycles). A second instance with
// THRESHOLD=255 exercises saturation with directed constant checks.
// ---------------------------------------------------------------------------
module tb_mod_lif_neuron;

    localparam int WIDTH       = 8;
    localparam int WEIGHT_W    = 8;
    localparam int THRESHOLD   = 100;
    localparam int LEAK_SHIFT  = 3;
    localparam int LEAK_PERIOD = 16;
    localparam int REFRACTORY  = 4;
    localparam int P_MAX       = (1 << WIDTH) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n;
    logic                       syn_valid;
    logic signed [WEIGHT_W-1:0] syn_weight;
    logic                       spike;
    logic                       crit;
    logic [WIDTH-1:0]           pot;
    logic                       refr;
    logic [1:0]                 dbg_state;

    logic                       s_rst_n;
    logic                       s_syn_valid;
    logic signed [WEIGHT_W-1:0] s_syn_weight;
    logic                       s_spike;
    logic                       s_crit;
    logic [WIDTH-1:0]           s_pot;
    logic                       s_refr;
    logic [1:0]                 s_dbg_state;

    mod_lif_neuron #(
        .WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W), .THRESHOLD(THRESHOLD),
        .LEAK_SHIFT(LEAK_SHIFT), .LEAK_PERIOD(LEAK_PERIOD), .REFRACTORY(REFRACTORY)
    ) dut (
        .clk(clk), .rstN(rst_n), .synValid(syn_valid), .synWeight(syn_weight),
        .spikeOut(spike), .crit(crit), .potential(pot), .refractory(refr),
        .o_dbg_state(dbg_state)
    );

    mod_lif_neuron #(
        .WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W), .THRESHOLD(255),
        .LEAK_SHIFT(LEAK_SHIFT), .LEAK_PERIOD(LEAK_PERIOD), .REFRACTORY(REFRACTORY)
    ) dut_sat (
        .clk(clk), .rstN(s_rst_n), .synValid(s_syn_valid), .synWeight(s_syn_weight),
        .spikeOut(s_spike), .crit(s_crit), .potential(s_pot), .refractory(s_refr),
        .o_dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    // {state[1:0], refractory, crit, spikeOut, potential[7:0]}
    logic [12:0] exp_q[$];

    int m_pot  = 0;
    int m_left = 0;   // remaining FIRE+REFRACT cycles; 0 means integrating
    int m_lcnt = 0;   // leak counter value in the current cycle

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the reference model by one rising edge and queue its outputs.
    task automatic model_step(input logic v, input int w, input logic rn);
        int p;
        bit tick;
        logic [1:0] st;
        logic e_spike, e_crit, e_refr;
        if (!rn) begin
            m_pot  = 0;
            m_left = 0;
            m_lcnt = 0;
        end else begin
            tick   = (m_lcnt == LEAK_PERIOD - 1);
            m_lcnt = tick ? 0 : m_lcnt + 1;
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_pot  = 0;
            end else begin
                p = m_pot;
                if (tick) p = p - (p >> LEAK_SHIFT);
                if (v) p = p + w;
                if (p < 0) p = 0;
                if (p > P_MAX) p = P_MAX;
                if (p >= THRESHOLD) begin
                    m_pot  = 0;
                    m_left = REFRACTORY + 1;
                end else begin
                    m_pot = p;
                end
            end
        end
        st      = (m_left == 0) ? 2'd0 : ((m_left == REFRACTORY + 1) ? 2'd1 : 2'd2);
        e_spike = (m_left >= 2);
        e_crit  = (m_left == REFRACTORY + 1) || (m_left == 1);
        e_refr  = (m_left > 0);
        exp_q.push_back({st, e_refr, e_crit, e_spike, 8'(m_pot)});
    endtask

    task automatic compare_outputs();
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            check_val("exp_queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_val("potential",  pot,       e[7:0]);
            check_val("spikeOut",   spike,     e[8]);
            check_val("crit",       crit,      e[9]);
            check_val("refractory", refr,      e[10]);
            check_val("state",      dbg_state, e[12:11]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int w, input logic rn);
        @(negedge clk);
        syn_valid  = v;
        syn_weight = w[WEIGHT_W-1:0];
        rst_n      = rn;
        @(posedge clk);
        model_step(v, w, rn);
        #1;
        compare_outputs();
    endtask

    task automatic run_until_tick();
        for (int i = 0; i < LEAK_PERIOD && m_lcnt != LEAK_PERIOD - 1; i++) begin
            drive(1'b0, 0, 1'b1);
        end
    endtask

    task automatic drive_sat(input logic v, input int w, input logic rn);
        @(negedge clk);
        s_syn_valid  = v;
        s_syn_weight = w[WEIGHT_W-1:0];
        s_rst_n      = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int crit_seen;
        int v, w;
        logic rn;

        rst_n = 1'b0; syn_valid = 1'b0; syn_weight = '0;
        s_rst_n = 1'b0; s_syn_valid = 1'b0; s_syn_weight = '0;

        // Reset with an event present.
        drive(1'b1, 50, 1'b0);
        drive(1'b1, 50, 1'b0);
        check_val("rst_pot",   pot,   0);
        check_val("rst_spike", spike, 0);
        check_val("rst_crit",  crit,  0);
        check_val("rst_refr",  refr,  0);

        // Fire and refractory.
        drive(1'b1, 40, 1'b1);
        check_val("fire_pot40", pot, 40);
        drive(1'b1, 40, 1'b1);
        check_val("fire_pot80", pot, 80);
        drive(1'b1, 40, 1'b1);
        check_val("fire_spike", spike, 1);
        check_val("fire_crit",  crit,  1);
        check_val("fire_pot0",  pot,   0);
        for (int i = 0; i < REFRACTORY - 1; i++) begin
            drive(1'b0, 0, 1'b1);
            check_val("refr_spike", spike, 1);
            check_val("refr_crit",  crit,  0);
        end
        drive(1'b0, 0, 1'b1);
        check_val("exit_crit",  crit,  1);
        check_val("exit_spike", spike, 0);
        drive(1'b0, 0, 1'b1);
        check_val("back_state", dbg_state, 0);
        check_val("back_refr",  refr, 0);

        // Leak.
        drive(1'b0, 0, 1'b0);
        drive(1'b1, 80, 1'b1);
        check_val("leak_load80", pot, 80);
        run_until_tick();
        drive(1'b0, 0, 1'b1);
        check_val("leak_70", pot, 70);
        run_until_tick();
        drive(1'b0, 0, 1'b1);
        check_val("leak_62", pot, 62);
        run_until_tick();
        drive(1'b1, 5, 1'b1);
        check_val("leak_evt_60", pot, 60);

        // Refractory gating.
        drive(1'b0, 0, 1'b0);
        drive(1'b1, 40, 1'b1);
        drive(1'b1, 40, 1'b1);
        drive(1'b1, 40, 1'b1);
        crit_seen = 0;
        for (int i = 0; i < REFRACTORY + 1; i++) begin
            drive(1'b1, 127, 1'b1);
            check_val("gate_pot0", pot, 0);
            if (crit) crit_seen++;
        end
        check_val("gate_crit_count", crit_seen, 1);
        drive(1'b1, 127, 1'b1);
        check_val("gate_refire_spike", spike, 1);
        check_val("gate_refire_crit",  crit,  1);

        // Reset in the second REFRACT cycle.
        drive(1'b0, 0, 1'b0);
        drive(1'b1, 40, 1'b1);
        drive(1'b1, 40, 1'b1);
        drive(1'b1, 40, 1'b1);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        check_val("midrst_spike", spike, 0);
        check_val("midrst_crit",  crit,  0);
        check_val("midrst_refr",  refr,  0);
        check_val("midrst_state", dbg_state, 0);
        crit_seen = 0;
        for (int i = 0; i < REFRACTORY + 2; i++) begin
            drive(1'b0, 0, 1'b1);
            if (crit) crit_seen++;
        end
        check_val("midrst_no_exit_crit", crit_seen, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v  = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) w = -int'($urandom_range(0, 128));
            else                           w = int'($urandom_range(0, 127));
            rn = ($urandom_range(0, 99) != 0);
            drive(v[0], w, rn);
        end

        // Saturation on the THRESHOLD=255 instance.
        drive_sat(1'b0, 0, 1'b0);
        drive_sat(1'b1, 50, 1'b1);
        check_val("sat_pot50", s_pot, 50);
        drive_sat(1'b1, -128, 1'b1);
        check_val("sat_floor0", s_pot, 0);
        drive_sat(1'b1, 127, 1'b1);
        check_val("sat_127", s_pot, 127);
        drive_sat(1'b1, 127, 1'b1);
        check_val("sat_254", s_pot, 254);
        check_val("sat_254_nofire", s_spike, 0);
        drive_sat(1'b1, 127, 1'b1);
        check_val("sat_fire_spike", s_spike, 1);
        check_val("sat_fire_crit",  s_crit,  1);
        check_val("sat_fire_pot0",  s_pot,   0);
        check_val("sat_fire_state", s_dbg_state, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
